// File: rtl/agc_pkg.sv
// Shared constants, state encoding and control-word layout for the AGC
// control sequencer and its decoder.
package agc_pkg;

    localparam int OP_W  = 3;
    localparam int ALU_W = 3;

    // Basic instruction opcodes (instruction bits [15:13]).
    localparam logic [OP_W-1:0] OP_TC   = 3'd0;
    localparam logic [OP_W-1:0] OP_RSV1 = 3'd1;
    localparam logic [OP_W-1:0] OP_RSV2 = 3'd2;
    localparam logic [OP_W-1:0] OP_XCH  = 3'd3;
    localparam logic [OP_W-1:0] OP_CS   = 3'd4;
    localparam logic [OP_W-1:0] OP_TS   = 3'd5;
    localparam logic [OP_W-1:0] OP_AD   = 3'd6;
    localparam logic [OP_W-1:0] OP_MASK = 3'd7;

    // ALU commands.
    localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_W-1:0] ALU_XOR = 3'd4;

    // Datapath mux selects.
    localparam logic [1:0] MADDR_PC = 2'd0;
    localparam logic [1:0] MADDR_S  = 2'd1;
    localparam logic [1:0] MADDR_A  = 2'd2;

    localparam logic [1:0] QSEL_MEM = 2'd0;
    localparam logic [1:0] QSEL_U   = 2'd1;
    localparam logic [1:0] QSEL_Z   = 2'd2;

    localparam logic [1:0] ASEL_MEM  = 2'd0;
    localparam logic [1:0] ASEL_U    = 2'd1;
    localparam logic [1:0] ASEL_NOTA = 2'd2;
    localparam logic [1:0] ASEL_G    = 2'd3;

    localparam logic [1:0] XSEL_MEM = 2'd0;
    localparam logic [1:0] XSEL_Z   = 2'd1;
    localparam logic [1:0] XSEL_S   = 2'd2;
    localparam logic [1:0] XSEL_A   = 2'd3;

    localparam logic [1:0] YSEL_MEM = 2'd0;
    localparam logic [1:0] YSEL_A   = 2'd1;
    localparam logic [1:0] YSEL_ONE = 2'd2;
    localparam logic [1:0] YSEL_IMM = 2'd3;

    localparam logic [1:0] ZSEL_MEM = 2'd0;
    localparam logic [1:0] ZSEL_U   = 2'd1;
    localparam logic [1:0] ZSEL_B   = 2'd2;

    localparam logic LPSEL_MEM = 1'b0;
    localparam logic LPSEL_U   = 1'b1;
    localparam logic BSEL_MEM  = 1'b0;
    localparam logic BSEL_U    = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        PCALU    = 3'd2,
        PCWB     = 3'd3,
        EX1      = 3'd4,
        EX2      = 3'd5,
        EX3      = 3'd6,
        DONE_ILL = 3'd7
    } state_t;

    typedef struct packed {
        logic [ALU_W-1:0] alu_op;
        logic [1:0]       maddr_mux;
        logic [1:0]       q_mux;
        logic [1:0]       a_mux;
        logic [1:0]       x_mux;
        logic [1:0]       y_mux;
        logic [1:0]       z_mux;
        logic             lp_mux;
        logic             b_mux;
        logic             lp_we;
        logic             g_we;
        logic             q_we;
        logic             b_we;
        logic             a_we;
        logic             x_we;
        logic             y_we;
        logic             z_we;
        logic             mem_we;
        logic             busy;
        logic             instr_done;
        logic             illegal_op;
    } ctl_t;

    // True for the reserved opcodes, which finish through DONE_ILL.
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op == OP_RSV1) || (op == OP_RSV2);
    endfunction

endpackage

// File: rtl/agc_ctl_decode.sv
// Combinational control-word decoder: (state, latched opcode) -> datapath controls.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | waiting for run or step, everything off
//   FETCH    | read mem[PC] into B, load X=Z (PC) and Y=1
//   PCALU    | ALU forms PC+1, opcode is latched
//   PCWB     | write PC+1 back to Z
//   EX1..EX3 | opcode-specific execute steps
//   DONE_ILL | unimplemented opcode, flag it and finish
module agc_ctl_decode
    import agc_pkg::*;
(
    input  state_t          i_state,
    input  logic [OP_W-1:0] i_op,
    output ctl_t            o_ctl
);

    // Build the control word; any field not set for a state stays 0.
    always_comb begin
        o_ctl        = '0;
        o_ctl.alu_op = ALU_ADD;
        o_ctl.busy   = (i_state != IDLE);
        case (i_state)
            IDLE: ;
            FETCH: begin
                o_ctl.maddr_mux = MADDR_PC;
                o_ctl.b_we      = 1'b1;
                o_ctl.b_mux     = BSEL_MEM;
                o_ctl.x_we      = 1'b1;
                o_ctl.x_mux     = XSEL_Z;
                o_ctl.y_we      = 1'b1;
                o_ctl.y_mux     = YSEL_ONE;
            end
            PCALU: o_ctl.alu_op = ALU_ADD;
            PCWB: begin
                o_ctl.z_we  = 1'b1;
                o_ctl.z_mux = ZSEL_U;
            end
            EX1: begin
                case (i_op)
                    OP_TC: begin
                        o_ctl.q_we  = 1'b1;
                        o_ctl.q_mux = QSEL_Z;
                    end
                    OP_XCH: begin
                        o_ctl.maddr_mux = MADDR_S;
                        o_ctl.g_we      = 1'b1;
                    end
                    OP_CS: begin
                        o_ctl.maddr_mux = MADDR_S;
                        o_ctl.a_we      = 1'b1;
                        o_ctl.a_mux     = ASEL_MEM;
                    end
                    OP_TS: begin
                        o_ctl.maddr_mux  = MADDR_S;
                        o_ctl.mem_we     = 1'b1;
                        o_ctl.instr_done = 1'b1;
                    end
                    OP_AD, OP_MASK: begin
                        o_ctl.maddr_mux = MADDR_S;
                        o_ctl.x_we      = 1'b1;
                        o_ctl.x_mux     = XSEL_A;
                        o_ctl.y_we      = 1'b1;
                        o_ctl.y_mux     = YSEL_MEM;
                    end
                    default: o_ctl.instr_done = 1'b1;
                endcase
            end
            EX2: begin
                case (i_op)
                    OP_TC: begin
                        o_ctl.z_we       = 1'b1;
                        o_ctl.z_mux      = ZSEL_B;
                        o_ctl.instr_done = 1'b1;
                    end
                    OP_XCH: begin
                        o_ctl.maddr_mux = MADDR_S;
                        o_ctl.mem_we    = 1'b1;
                    end
                    OP_CS: begin
                        o_ctl.a_we       = 1'b1;
                        o_ctl.a_mux      = ASEL_NOTA;
                        o_ctl.instr_done = 1'b1;
                    end
                    OP_AD:   o_ctl.alu_op = ALU_ADD;
                    OP_MASK: o_ctl.alu_op = ALU_AND;
                    default: o_ctl.instr_done = 1'b1;
                endcase
            end
            EX3: begin
                case (i_op)
                    OP_XCH: begin
                        o_ctl.a_we  = 1'b1;
                        o_ctl.a_mux = ASEL_G;
                    end
                    OP_AD, OP_MASK: begin
                        o_ctl.a_we  = 1'b1;
                        o_ctl.a_mux = ASEL_U;
                    end
                    default: ;
                endcase
                // EX3 is the last step of any opcode that reaches it.
                o_ctl.instr_done = 1'b1;
            end
            DONE_ILL: begin
                o_ctl.illegal_op = 1'b1;
                o_ctl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/agc_sequencer.sv
// AGC control sequencer: state register, latched opcode and one-shot flag;
// the control word itself comes from agc_ctl_decode.
module agc_sequencer
    import agc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [OP_W-1:0]  instr_op,
    output logic [ALU_W-1:0] alu_op,
    output logic [1:0]       MAddr_MUX,
    output logic [1:0]       Q_MUX,
    output logic [1:0]       A_MUX,
    output logic [1:0]       X_MUX,
    output logic [1:0]       Y_MUX,
    output logic [1:0]       Z_MUX,
    output logic             LP_MUX,
    output logic             B_MUX,
    output logic             LP_WE,
    output logic             G_WE,
    output logic             Q_WE,
    output logic             B_WE,
    output logic             A_WE,
    output logic             X_WE,
    output logic             Y_WE,
    output logic             Z_WE,
    output logic             mem_WE,
    output logic             busy,
    output logic             instr_done,
    output logic             illegal_op
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OP_W-1:0] r_op_q;
    logic            r_one_shot;
    logic            w_one_shot_nxt;
    ctl_t            w_ctl;

    agc_ctl_decode u_decode (
        .i_state (r_state),
        .i_op    (r_op_q),
        .o_ctl   (w_ctl)
    );

    // Next-state logic; the decoder's instr_done marks the last step of an instruction.
    always_comb begin
        w_state_nxt    = r_state;
        w_one_shot_nxt = r_one_shot;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_nxt    = FETCH;
                    w_one_shot_nxt = 1'b0;
                end else if (step) begin
                    w_state_nxt    = FETCH;
                    w_one_shot_nxt = 1'b1;
                end
            end
            FETCH: w_state_nxt = PCALU;
            PCALU: w_state_nxt = PCWB;
            PCWB:  w_state_nxt = op_is_illegal(r_op_q) ? DONE_ILL : EX1;
            default: begin
                if (w_ctl.instr_done) begin
                    w_one_shot_nxt = 1'b0;
                    w_state_nxt    = run ? FETCH : IDLE;
                end else if (r_state == EX1) begin
                    w_state_nxt = EX2;
                end else if (r_state == EX2) begin
                    w_state_nxt = EX3;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    // State, one-shot flag and opcode latch (opcode captured only in PCALU).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_one_shot <= 1'b0;
            r_op_q     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_one_shot <= w_one_shot_nxt;
            if (r_state == PCALU) begin
                r_op_q <= instr_op;
            end
        end
    end

    assign alu_op     = w_ctl.alu_op;
    assign MAddr_MUX  = w_ctl.maddr_mux;
    assign Q_MUX      = w_ctl.q_mux;
    assign A_MUX      = w_ctl.a_mux;
    assign X_MUX      = w_ctl.x_mux;
    assign Y_MUX      = w_ctl.y_mux;
    assign Z_MUX      = w_ctl.z_mux;
    assign LP_MUX     = w_ctl.lp_mux;
    assign B_MUX      = w_ctl.b_mux;
    assign LP_WE      = w_ctl.lp_we;
    assign G_WE       = w_ctl.g_we;
    assign Q_WE       = w_ctl.q_we;
    assign B_WE       = w_ctl.b_we;
    assign A_WE       = w_ctl.a_we;
    assign X_WE       = w_ctl.x_we;
    assign Y_WE       = w_ctl.y_we;
    assign Z_WE       = w_ctl.z_we;
    assign mem_WE     = w_ctl.mem_we;
    assign busy       = w_ctl.busy;
    assign instr_done = w_ctl.instr_done;
    assign illegal_op = w_ctl.illegal_op;

endmodule

// File: tb/tb_agc_sequencer.sv
// Scoreboard bench for agc_sequencer: an instruction-level reference model
// queues the control word expected after each clock; a monitor compares.
module tb_agc_sequencer;

    logic       clk = 1'b1;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [2:0] instr_op = 3'd0;
    logic [2:0] alu_op;
    logic [1:0] MAddr_MUX, Q_MUX, A_MUX, X_MUX, Y_MUX, Z_MUX;
    logic       LP_MUX, B_MUX;
    logic       LP_WE, G_WE, Q_WE, B_WE, A_WE, X_WE, Y_WE, Z_WE, mem_WE;
    logic       busy, instr_done, illegal_op;

    agc_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .instr_op(instr_op),
        .alu_op(alu_op), .MAddr_MUX(MAddr_MUX), .Q_MUX(Q_MUX), .A_MUX(A_MUX),
        .X_MUX(X_MUX), .Y_MUX(Y_MUX), .Z_MUX(Z_MUX), .LP_MUX(LP_MUX), .B_MUX(B_MUX),
        .LP_WE(LP_WE), .G_WE(G_WE), .Q_WE(Q_WE), .B_WE(B_WE), .A_WE(A_WE),
        .X_WE(X_WE), .Y_WE(Y_WE), .Z_WE(Z_WE), .mem_WE(mem_WE),
        .busy(busy), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu;
        logic [1:0] maddr, qm, am, xm, ym, zm;
        logic lpm, bm;
        logic lp_we, g_we, q_we, b_we, a_we, x_we, y_we, z_we, mem_we;
        logic busy, done, ill;
    } word_t;

    word_t exp_q[$];
    word_t rem[$];
    bit    pend_pcalu;
    bit    need_op;
    bit    idle_now;
    int    checks = 0;
    int    errors = 0;

    function automatic word_t busy_w();
        word_t w = '0;
        w.busy = 1'b1;
        return w;
    endfunction

    function automatic word_t fetch_w();
        word_t w = busy_w();
        w.b_we = 1'b1;
        w.x_we = 1'b1; w.xm = 2'd1;
        w.y_we = 1'b1; w.ym = 2'd2;
        return w;
    endfunction

    // Words from PCWB to the end of the instruction, straight from the opcode table.
    function automatic void build_instr(input logic [2:0] op);
        word_t seq[$];
        word_t w;
        w = busy_w(); w.z_we = 1'b1; w.zm = 2'd1; seq.push_back(w);
        case (op)
            3'd0: begin
                w = busy_w(); w.q_we = 1'b1; w.qm = 2'd2; seq.push_back(w);
                w = busy_w(); w.z_we = 1'b1; w.zm = 2'd2; seq.push_back(w);
            end
            3'd3: begin
                w = busy_w(); w.maddr = 2'd1; w.g_we = 1'b1; seq.push_back(w);
                w = busy_w(); w.maddr = 2'd1; w.mem_we = 1'b1; seq.push_back(w);
                w = busy_w(); w.a_we = 1'b1; w.am = 2'd3; seq.push_back(w);
            end
            3'd4: begin
                w = busy_w(); w.maddr = 2'd1; w.a_we = 1'b1; w.am = 2'd0; seq.push_back(w);
                w = busy_w(); w.a_we = 1'b1; w.am = 2'd2; seq.push_back(w);
            end
            3'd5: begin
                w = busy_w(); w.maddr = 2'd1; w.mem_we = 1'b1; seq.push_back(w);
            end
            3'd6, 3'd7: begin
                w = busy_w(); w.maddr = 2'd1; w.x_we = 1'b1; w.xm = 2'd3;
                w.y_we = 1'b1; w.ym = 2'd0; seq.push_back(w);
                w = busy_w(); w.alu = (op == 3'd7) ? 3'd2 : 3'd0; seq.push_back(w);
                w = busy_w(); w.a_we = 1'b1; w.am = 2'd1; seq.push_back(w);
            end
            default: begin
                w = busy_w(); w.ill = 1'b1; seq.push_back(w);
            end
        endcase
        rem.delete();
        for (int i = 0; i < seq.size(); i++) begin
            w = seq[i];
            if (i == seq.size() - 1) w.done = 1'b1;
            rem.push_back(w);
        end
    endfunction

    // Reference model: given the inputs seen at the coming edge, queue the word expected after it.
    function automatic void model(input logic r, input logic ru, input logic st, input logic [2:0] op);
        word_t e;
        if (r) begin
            rem.delete();
            pend_pcalu = 0;
            need_op    = 0;
            idle_now   = 1;
            e = '0;
        end else if (pend_pcalu) begin
            pend_pcalu = 0;
            need_op    = 1;
            e = busy_w();
        end else if (need_op) begin
            need_op = 0;
            build_instr(op);
            e = rem.pop_front();
        end else if (rem.size() > 0) begin
            e = rem.pop_front();
        end else if (ru || (idle_now && st)) begin
            idle_now   = 0;
            pend_pcalu = 1;
            e = fetch_w();
        end else begin
            idle_now = 1;
            e = '0;
        end
        exp_q.push_back(e);
    endfunction

    task automatic drive(input logic r, input logic ru, input logic st, input logic [2:0] op);
        @(negedge clk);
        reset = r; run = ru; step = st; instr_op = op;
        model(r, ru, st, op);
    endtask

    task automatic idle_cycles(input int n, input logic [2:0] op);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, op);
    endtask

    // Monitor: one control word per clock, compared after the edge settles.
    initial begin
        word_t e;
        word_t g;
        forever begin
            @(posedge clk);
            #1;
            g = {alu_op, MAddr_MUX, Q_MUX, A_MUX, X_MUX, Y_MUX, Z_MUX, LP_MUX, B_MUX,
                 LP_WE, G_WE, Q_WE, B_WE, A_WE, X_WE, Y_WE, Z_WE, mem_WE,
                 busy, instr_done, illegal_op};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underrun t=%0t got=%h required=<queued word>", $time, g);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL ctl_word t=%0t got=%h required=%h", $time, g, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       r_run;
        logic [2:0] r_op;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 3'd0);
        idle_cycles(2, 3'd0);

        // AD back to back, then drain
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 3'd6);
        idle_cycles(8, 3'd6);

        // single step of XCH
        drive(1'b0, 1'b0, 1'b1, 3'd3);
        idle_cycles(8, 3'd3);

        // TC under run, then illegal opcode 2
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 3'd0);
        idle_cycles(6, 3'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 3'd2);
        idle_cycles(5, 3'd2);

        // MASK with run dropped while in EX1; opcode changes after PCALU are ignored
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 3'd7);
        idle_cycles(6, 3'd1);

        // reset during EX2 of XCH, then a normal step
        drive(1'b0, 1'b0, 1'b1, 3'd3);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 3'd3);
        drive(1'b1, 1'b0, 1'b0, 3'd3);
        idle_cycles(2, 3'd3);
        drive(1'b0, 1'b0, 1'b1, 3'd3);
        idle_cycles(8, 3'd3);

        // step together with run: run dominates
        drive(1'b0, 1'b1, 1'b1, 3'd5);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 3'd5);
        idle_cycles(6, 3'd5);

        // randomized traffic
        r_run = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) r_run = ~r_run;
            r_op = 3'($urandom_range(0, 7));
            drive(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, r_run,
                  ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0, r_op);
        end
        idle_cycles(8, 3'd0);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d required=0 words left", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
